// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and helpers for the pending priority encoder
// Purpose: request-line count, code width, FSM state type and the code-to-onehot
//          helper used by the encoder and by anything that decodes its output.
// Ports:   none (package).
package enc_pkg;

  localparam int ENC_N = 8;
  localparam int ENC_W = $clog2(ENC_N);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } enc_state_t;

  // Binary code back to a single set bit.
  function automatic logic [ENC_N-1:0] onehot(input logic [ENC_W-1:0] c);
    logic [ENC_N-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pending_priority_encoder_prio_find.sv
// rtl/pending_priority_encoder_prio_find.sv - combinational fixed-priority finder
// Purpose: returns the index of the winning set bit of vec_i.
//          HIGH_FIRST=1 picks the highest set index, 0 picks the lowest.
// Ports:   vec_i   [N-1:0] candidate vector
//          idx_o   [W-1:0] winning index (0 when nothing is set)
//          found_o         at least one bit of vec_i is set
module prio_find #(
  parameter int N          = 8,
  parameter int W          = $clog2(N),
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Scan so that the preferred end is visited last and overwrites earlier hits.
  always_comb begin
    idx_o = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (vec_i[i]) idx_o = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec_i[i]) idx_o = W'(i);
      end
    end
  end

  assign found_o = |vec_i;

endmodule

// File: rtl/pending_priority_encoder.sv
// rtl/pending_priority_encoder.sv - sticky pending register with priority-encoded valid/ready output
// Purpose: captures request lines into a sticky pending register and offers one
//          winning index at a time as a binary code; an accepted code clears its bit.
// Ports:   clk, rst        clock, async active-high reset
//          en              capture enable for req
//          req   [N-1:0]   request lines
//          clr             synchronous flush of pend, ovf, code/valid
//          code  [W-1:0]   offered index
//          valid           code is valid
//          ready           consumer accepts on valid & ready
//          pend  [N-1:0]   pending register
//          any             |pend
//          ovf             sticky: request landed on an already-pending bit
module pending_priority_encoder
  import enc_pkg::*;
#(
  parameter int N  = ENC_N,
  parameter int RR = 0,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         clr,
  output logic [W-1:0] code,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pend,
  output logic         any,
  output logic         ovf
);

  enc_state_t   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] code_q, code_d;
  logic         valid_q, valid_d;

  logic         acc;
  logic [N-1:0] acc_mask;
  logic [N-1:0] pend_rem;
  logic [N-1:0] req_cap;
  logic [W-1:0] ptr_eff;
  logic [W-1:0] rot_amt;
  logic [W-1:0] rot_j;
  logic [N-1:0] find_vec;
  logic [W-1:0] find_idx;
  logic         found;
  logic [W-1:0] sel;

  assign acc      = valid_q & ready;
  assign acc_mask = acc ? ({{(N-1){1'b0}}, 1'b1} << code_q) : '0;
  assign pend_rem = pend_q & ~acc_mask;
  assign req_cap  = en ? req : '0;

  // The pointer advance and the next-winner search share an edge, so the
  // search already starts just past the code being accepted.
  assign ptr_eff  = acc ? (code_q + W'(1)) : ptr_q;
  assign rot_amt  = (RR != 0) ? ptr_eff : '0;

  // Rotate right by rot_amt; W-bit index arithmetic wraps mod N.
  always_comb begin
    find_vec = '0;
    rot_j    = '0;
    for (int i = 0; i < N; i++) begin
      rot_j       = W'(i) + rot_amt;
      find_vec[i] = pend_rem[rot_j];
    end
  end

  prio_find #(
    .N          (N),
    .W          (W),
    .HIGH_FIRST (RR == 0)
  ) u_find (
    .vec_i   (find_vec),
    .idx_o   (find_idx),
    .found_o (found)
  );

  assign sel = find_idx + rot_amt;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    // A new request on a bit being accepted this edge keeps it set.
    pend_d  = pend_rem | req_cap;
    ovf_d   = ovf_q | (|(req_cap & pend_rem));

    case (state_q)
      IDLE: begin
        if (found) begin
          code_d  = sel;
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (acc) begin
          ptr_d = ptr_eff;
          if (found) begin
            code_d = sel;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (clr) begin
      pend_d  = '0;
      ovf_d   = 1'b0;
      code_d  = '0;
      valid_d = 1'b0;
      state_d = IDLE;
      ptr_d   = ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      ptr_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign code  = code_q;
  assign valid = valid_q;
  assign pend  = pend_q;
  assign any   = |pend_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// tb/tb_pending_priority_encoder.sv - directed self-checking bench for pending_priority_encoder
module tb_pending_priority_encoder;
  import enc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       clr;
  logic       ready;

  logic [2:0] f_code, r_code;
  logic       f_valid, r_valid;
  logic [7:0] f_pend, r_pend;
  logic       f_any, r_any;
  logic       f_ovf, r_ovf;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pending_priority_encoder #(.N(8), .RR(0)) u_fix (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .req   (req),
    .clr   (clr),
    .code  (f_code),
    .valid (f_valid),
    .ready (ready),
    .pend  (f_pend),
    .any   (f_any),
    .ovf   (f_ovf)
  );

  pending_priority_encoder #(.N(8), .RR(1)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .req   (req),
    .clr   (clr),
    .code  (r_code),
    .valid (r_valid),
    .ready (ready),
    .pend  (r_pend),
    .any   (r_any),
    .ovf   (r_ovf)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; clr = 1'b0; ready = 1'b0;
    repeat (2) tick();
    check("rst_pend",  f_pend,  8'h00);
    check("rst_valid", f_valid, 0);
    check("rst_code",  f_code,  0);
    check("rst_any",   f_any,   0);
    check("rst_ovf",   f_ovf,   0);
    rst = 1'b0;
    tick();

    // Fixed priority drain of A4: 7, 5, 2 back to back.
    en = 1'b1; req = 8'hA4; ready = 1'b1;
    tick();
    check("fp_pend0",  f_pend,  8'hA4);
    check("fp_valid0", f_valid, 0);
    req = '0;
    tick();
    check("fp_code7",  f_code,  7);
    check("fp_valid7", f_valid, 1);
    check("fp_dec7",   onehot(f_code), 8'h80);
    tick();
    check("fp_code5",  f_code,  5);
    check("fp_pend5",  f_pend,  8'h24);
    check("fp_dec5",   onehot(f_code), 8'h20);
    tick();
    check("fp_code2",  f_code,  2);
    check("fp_pend2",  f_pend,  8'h04);
    check("fp_dec2",   onehot(f_code), 8'h04);
    tick();
    check("fp_valid_end", f_valid, 0);
    check("fp_pend_end",  f_pend,  8'h00);
    check("fp_any_end",   f_any,   0);
    check("fp_ovf_end",   f_ovf,   0);

    // Stall: code 3 held, later request 7 does not pre-empt.
    ready = 1'b0; req = 8'h08;
    tick();
    req = '0;
    tick();
    check("st_code",  f_code,  3);
    check("st_valid", f_valid, 1);
    repeat (2) tick();
    req = 8'h80;
    tick();
    req = '0;
    tick();
    check("st_code_hold", f_code,  3);
    check("st_valid_hold", f_valid, 1);
    check("st_pend",  f_pend,  8'h88);
    ready = 1'b1;
    tick();
    check("st_code7", f_code, 7);
    check("st_pend7", f_pend, 8'h80);
    tick();
    check("st_valid_end", f_valid, 0);

    // Re-request on the accepting edge, then overflow.
    ready = 1'b0; req = 8'h10;
    tick();
    req = '0;
    tick();
    check("rr4_code", f_code, 4);
    ready = 1'b1; req = 8'h10;
    tick();
    check("rr4_pend",  f_pend,  8'h10);
    check("rr4_ovf",   f_ovf,   0);
    ready = 1'b0; req = '0;
    tick();
    check("rr4_reoffer", f_code,  4);
    check("rr4_revalid", f_valid, 1);
    req = 8'h10;
    tick();
    check("ovf_set", f_ovf, 1);
    req = 8'h01;
    tick();
    check("ovf_sticky", f_ovf,  1);
    check("clr_pre_pend", f_pend, 8'h11);
    check("clr_pre_valid", f_valid, 1);
    req = '0; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_pend",  f_pend,  8'h00);
    check("clr_valid", f_valid, 0);
    check("clr_code",  f_code,  0);
    check("clr_ovf",   f_ovf,   0);

    // en=0 ignores requests but still services pending bits.
    req = 8'h02;
    tick();
    en = 1'b0; req = 8'hFF;
    tick();
    check("en0_pend",  f_pend,  8'h02);
    check("en0_ovf",   f_ovf,   0);
    check("en0_code",  f_code,  1);
    check("en0_valid", f_valid, 1);

    // Asynchronous reset mid-OFFER.
    rst = 1'b1;
    #1;
    check("arst_valid", f_valid, 0);
    check("arst_code",  f_code,  0);
    check("arst_pend",  f_pend,  8'h00);
    check("arst_any",   f_any,   0);
    check("arst_ovf",   f_ovf,   0);
    tick();
    rst = 1'b0;

    // Round robin with all lines requesting: 0..7 then wrap.
    en = 1'b1; req = 8'hFF; ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rr_code%0d", i), r_code, i % 8);
      check($sformatf("rr_valid%0d", i), r_valid, 1);
      if (i == 0) check("fix_code_a", f_code, 7);
      if (i == 1) check("fix_code_b", f_code, 6);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
